// File: rtl/ifetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package ifetch_pkg;

  localparam int unsigned W_DEF     = 32;
  localparam int unsigned DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {PC, instruction} pairs; head outputs are registered
// and hold their last value while the queue is empty.
module fetch_queue #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             push_pc,
  input  logic [W-1:0]             push_instr,
  output logic [W-1:0]             head_pc,
  output logic [W-1:0]             head_instr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  pc_mem [DEPTH];
  logic [W-1:0]  in_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic          do_pop;
  logic [W-1:0]  nxt_pc;
  logic [W-1:0]  nxt_instr;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign rd_nxt = rd_ptr + AW'(1);

  // Head value after this edge; unchanged whenever the queue ends up empty.
  always_comb begin
    nxt_pc    = head_pc;
    nxt_instr = head_instr;
    if (!flush) begin
      if (do_pop) begin
        if (count > CW'(1)) begin
          nxt_pc    = pc_mem[rd_nxt];
          nxt_instr = in_mem[rd_nxt];
        end else if (push) begin
          nxt_pc    = push_pc;
          nxt_instr = push_instr;
        end
      end else if (push && empty) begin
        nxt_pc    = push_pc;
        nxt_instr = push_instr;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_pc    <= '0;
      head_instr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem[i] <= '0;
        in_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      head_pc    <= nxt_pc;
      head_instr <= nxt_instr;
      if (push) begin
        pc_mem[wr_ptr] <= push_pc;
        in_mem[wr_ptr] <= push_instr;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_nxt;
      if (push && !do_pop)      count <= count + CW'(1);
      else if (!push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: one outstanding instruction-memory read, queue toward decode,
// and PC stall generation. Flushed in-flight reads are drained, never pushed.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] PCF,
  input  logic         FlushD,
  input  logic         StallD,
  output logic         IMemReq,
  output logic [W-1:0] IMemAddr,
  input  logic         IMemAck,
  input  logic [W-1:0] IMemRData,
  output logic [W-1:0] InstrD,
  output logic [W-1:0] PCD,
  output logic         ValidD,
  output logic         StallF
);

  fetch_state_t state, state_n;
  logic         req_n;
  logic [W-1:0] addr_n;
  logic         accept;
  logic         q_pop;
  logic         q_full;
  logic         q_empty;
  logic [$clog2(DEPTH):0] q_count;

  assign accept = !RST && (state == WAIT) && IMemAck && !FlushD;
  assign StallF = RST || !(accept || FlushD);
  assign ValidD = (q_count != '0);
  assign q_pop  = !q_empty && !StallD;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      IMemReq  <= 1'b0;
      IMemAddr <= '0;
    end else begin
      state    <= state_n;
      IMemReq  <= req_n;
      IMemAddr <= addr_n;
    end
  end

  // Request stays up until acked, even across a flush, since it cannot be withdrawn.
  always_comb begin
    state_n = state;
    req_n   = IMemReq;
    addr_n  = IMemAddr;
    case (state)
      IDLE: begin
        if (!FlushD && !q_full) begin
          req_n   = 1'b1;
          addr_n  = PCF;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (IMemAck) begin
          req_n   = 1'b0;
          state_n = IDLE;
        end else if (FlushD) begin
          state_n = DISCARD;
        end
      end
      DISCARD: begin
        if (IMemAck) begin
          req_n   = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        req_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  fetch_queue #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_queue (
    .CLK        (CLK),
    .RST        (RST),
    .push       (accept),
    .pop        (q_pop),
    .flush      (FlushD),
    .push_pc    (IMemAddr),
    .push_instr (IMemRData),
    .head_pc    (PCD),
    .head_instr (InstrD),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus random traffic, all checked
// against a transaction-level model (outstanding read + poison flag + queue).
module tb_ifetch_unit;

  localparam int W     = 32;
  localparam int DEPTH = 2;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] PCF = '0;
  logic         FlushD = 1'b0;
  logic         StallD = 1'b0;
  logic         IMemReq;
  logic [W-1:0] IMemAddr;
  logic         IMemAck = 1'b0;
  logic [W-1:0] IMemRData = '0;
  logic [W-1:0] InstrD;
  logic [W-1:0] PCD;
  logic         ValidD;
  logic         StallF;

  ifetch_unit #(.W(W), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PCF       (PCF),
    .FlushD    (FlushD),
    .StallD    (StallD),
    .IMemReq   (IMemReq),
    .IMemAddr  (IMemAddr),
    .IMemAck   (IMemAck),
    .IMemRData (IMemRData),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .ValidD    (ValidD),
    .StallF    (StallF)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic              m_req = 1'b0;
  logic              m_poison = 1'b0;
  logic [W-1:0]      m_addr = '0;
  logic [2*W-1:0]    q[$];
  logic [W-1:0]      m_hpc = '0;
  logic [W-1:0]      m_hin = '0;
  logic [W-1:0]      pc = '0;
  logic              last_stallf;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare every output, advance the model.
  task automatic step(input logic rst, input logic flush, input logic stalld,
                      input logic ack, input logic [W-1:0] rdata, input logic [W-1:0] tgt);
    int   sz;
    logic acc;
    logic exp_stall;
    RST = rst; FlushD = flush; StallD = stalld; IMemAck = ack; IMemRData = rdata; PCF = pc;
    #1;
    acc       = !rst && m_req && !m_poison && ack && !flush;
    exp_stall = rst || !(acc || flush);
    check("StallF",   W'(StallF),  W'(exp_stall));
    check("IMemReq",  W'(IMemReq), W'(m_req));
    check("IMemAddr", IMemAddr,    m_addr);
    check("ValidD",   W'(ValidD),  W'(q.size() > 0));
    check("PCD",      PCD,         m_hpc);
    check("InstrD",   InstrD,      m_hin);
    last_stallf = StallF;
    if (rst) begin
      m_req = 1'b0; m_poison = 1'b0; m_addr = '0; q.delete();
      m_hpc = '0; m_hin = '0; pc = '0;
    end else begin
      sz = q.size();
      if (flush) q.delete();
      else begin
        if (sz > 0 && !stalld) void'(q.pop_front());
        if (acc) q.push_back({m_addr, rdata});
      end
      if (q.size() > 0) {m_hpc, m_hin} = q[0];
      if (m_req) begin
        if (ack) begin m_req = 1'b0; m_poison = 1'b0; end
        else if (flush) m_poison = 1'b1;
      end else if (!flush && sz < DEPTH) begin
        m_req = 1'b1; m_addr = pc;
      end
      if (flush) pc = tgt;
      else if (acc) pc = pc + 32'd4;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset with a stray ack present
    step(1, 0, 0, 1, 32'hdeadbeef, 0);
    step(1, 0, 0, 1, 32'hdeadbeef, 0);
    check("rst_stallf", W'(last_stallf), 32'd1);
    check("rst_req",    W'(IMemReq), 32'd0);
    check("rst_valid",  W'(ValidD),  32'd0);
    check("rst_pcd",    PCD,         32'd0);

    // Single fetch, acked after three waiting cycles
    pc = 32'h40;
    step(0, 0, 0, 0, 0, 0);
    check("sf_req",  W'(IMemReq), 32'd1);
    check("sf_addr", IMemAddr,    32'h40);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      check("sf_wait_stallf", W'(last_stallf), 32'd1);
    end
    step(0, 0, 0, 1, 32'h20080005, 0);
    check("sf_ack_stallf", W'(last_stallf), 32'd0);
    check("sf_valid", W'(ValidD), 32'd1);
    check("sf_pcd",   PCD,        32'h40);
    check("sf_instr", InstrD,     32'h20080005);

    // Fill the queue with decode stalled
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 32'h11110000, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 32'h11110004, 0);
    step(0, 0, 1, 0, 0, 0);
    check("fill_noreq", W'(IMemReq), 32'd0);
    check("fill_pcd",   PCD,         32'h0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("fill_req",   W'(IMemReq), 32'd1);
    check("fill_addr",  IMemAddr,    32'h8);
    check("fill_pcd1",  PCD,         32'h4);

    // Flush while the read for 0x8 is in flight; ack two cycles later
    step(0, 1, 0, 0, 0, 32'h100);
    check("fl_stallf", W'(last_stallf), 32'd0);
    check("fl_empty",  W'(ValidD), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    check("fl_stallf1", W'(last_stallf), 32'd1);
    step(0, 0, 0, 1, 32'hbad0bad0, 0);
    check("fl_stallf2", W'(last_stallf), 32'd1);
    check("fl_nopush", W'(ValidD), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    check("fl_newaddr", IMemAddr, 32'h100);

    // Flush coinciding with ack
    step(0, 1, 0, 1, 32'hbad1bad1, 32'h200);
    check("fa_valid", W'(ValidD),  32'd0);
    check("fa_req",   W'(IMemReq), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    check("fa_addr",  IMemAddr,    32'h200);

    // Reset in the middle of a wait; a later ack is ignored
    step(1, 0, 0, 0, 0, 0);
    check("rw_req", W'(IMemReq), 32'd0);
    step(0, 0, 0, 1, 32'hbad2bad2, 0);
    check("rw_valid", W'(ValidD), 32'd0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      logic r, f, s, a;
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 11) == 0);
      s = ($urandom_range(0, 2) == 0);
      a = IMemReq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      step(r, f, s, a, $urandom, $urandom & 32'hffff_fffc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
